// File: rtl/spi_slave_regif.sv
// SPI slave to register-bank bridge; all SPI pins are oversampled in the clk domain.
// Optional sticky frame-error flag is built when SPI_FRAME_ERR_EN is defined.
module spi_slave_regif #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7,
  parameter bit          CPOL   = 1'b0,
  parameter bit          CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSPI_SCK,
  input  logic              iSPI_SS_n,
  input  logic              iSPI_MOSI,
  output logic              oSPI_MISO,
  output logic              oSPI_MISO_OE,
  output logic [ADDR_W-1:0] oREG_ADDR,
  output logic [DATA_W-1:0] oREG_WDATA,
  output logic              oREG_WR,
  output logic              oREG_RD,
  input  logic [DATA_W-1:0] iREG_RDATA,
  input  logic              iREG_RVALID,
  output logic              oBUSY,
  output logic              oFRAME_ERR
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned CMD_W  = 8;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} stateT;

  // 2-FF synchronisers followed by one edge-detect stage
  logic [1:0] sckSync, ssSync, mosiSync;
  logic       sckPrev, ssPrev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sckSync  <= {CPOL, CPOL};
      ssSync   <= 2'b11;
      mosiSync <= 2'b00;
      sckPrev  <= CPOL;
      ssPrev   <= 1'b1;
    end else begin
      sckSync  <= {sckSync[0], iSPI_SCK};
      ssSync   <= {ssSync[0], iSPI_SS_n};
      mosiSync <= {mosiSync[0], iSPI_MOSI};
      sckPrev  <= sckSync[1];
      ssPrev   <= ssSync[1];
    end
  end

  logic sckRise, sckFall, sampleEdge, shiftEdge;
  logic ssHigh, ssFall, mosiBit;

  assign sckRise    = sckSync[1] & ~sckPrev;
  assign sckFall    = ~sckSync[1] & sckPrev;
  assign sampleEdge = (CPOL ^ CPHA) ? sckFall : sckRise;
  assign shiftEdge  = (CPOL ^ CPHA) ? sckRise : sckFall;
  assign ssHigh     = ssSync[1];
  assign ssFall     = ssPrev & ~ssSync[1];
  assign mosiBit    = mosiSync[1];

  stateT             state, stateNxt;
  logic [CNT_W-1:0]  bitCnt, cntNxt;
  logic [DATA_W-2:0] rxShift, rxNxt;
  logic [DATA_W-1:0] txShift, txNxt;
  logic [DATA_W-1:0] holdReg, holdNxt;
  logic              holdValid, holdValidNxt;
  logic              rdPend, rdPendNxt;
  logic [ADDR_W-1:0] addrNxt;
  logic [DATA_W-1:0] wdataNxt;
  logic              wrNxt, rdNxt;
  logic [CMD_W-1:0]  cmdByte;
  logic [DATA_W-1:0] dataWord;

`ifdef SPI_FRAME_ERR_EN
  logic ssRise, frameErr, errNxt;
  assign ssRise = ~ssPrev & ssSync[1];
`endif

  // next-state and registered-output logic
  always_comb begin
    stateNxt     = state;
    cntNxt       = bitCnt;
    rxNxt        = rxShift;
    txNxt        = txShift;
    holdNxt      = holdReg;
    holdValidNxt = holdValid;
    rdPendNxt    = 1'b0;
    addrNxt      = oREG_ADDR;
    wdataNxt     = oREG_WDATA;
    wrNxt        = 1'b0;
    rdNxt        = rdPend;
    cmdByte      = {rxShift[CMD_W-2:0], mosiBit};
    dataWord     = {rxShift, mosiBit};

    // a response arriving with the request belongs to that request
    if (iREG_RVALID) begin
      holdNxt      = iREG_RDATA;
      holdValidNxt = 1'b1;
    end else if (oREG_RD) begin
      holdValidNxt = 1'b0;
    end

    if (oREG_WR) addrNxt = oREG_ADDR + ADDR_W'(1);

    case (state)
      IDLE: begin
        cntNxt = '0;
        rxNxt  = '0;
        txNxt  = '0;
        if (ssFall) stateNxt = CMD;
      end
      CMD: begin
        if (sampleEdge) begin
          rxNxt = dataWord[DATA_W-2:0];
          if (bitCnt == CNT_W'(CMD_W - 1)) begin
            cntNxt  = '0;
            addrNxt = cmdByte[ADDR_W-1:0];
            if (cmdByte[CMD_W-1]) begin
              stateNxt = WDATA;
            end else begin
              stateNxt = RDATA;
              rdNxt    = 1'b1;
            end
          end else begin
            cntNxt = bitCnt + CNT_W'(1);
          end
        end
      end
      WDATA: begin
        if (sampleEdge) begin
          rxNxt = dataWord[DATA_W-2:0];
          if (bitCnt == CNT_W'(DATA_W - 1)) begin
            cntNxt   = '0;
            wdataNxt = dataWord;
            wrNxt    = 1'b1;
          end else begin
            cntNxt = bitCnt + CNT_W'(1);
          end
        end
      end
      RDATA: begin
        // first shift edge of a word reloads from the holding register
        if (shiftEdge) begin
          if (bitCnt == '0) txNxt = holdValid ? holdReg : '0;
          else              txNxt = {txShift[DATA_W-2:0], 1'b0};
        end
        if (sampleEdge) begin
          if (bitCnt == CNT_W'(DATA_W - 1)) begin
            cntNxt    = '0;
            addrNxt   = oREG_ADDR + ADDR_W'(1);
            rdPendNxt = 1'b1;
          end else begin
            cntNxt = bitCnt + CNT_W'(1);
          end
        end
      end
      default: stateNxt = IDLE;
    endcase

    // deselect aborts the frame from anywhere, dropping any partial word
    if (ssHigh) begin
      stateNxt  = IDLE;
      cntNxt    = '0;
      txNxt     = '0;
      rdPendNxt = 1'b0;
    end

`ifdef SPI_FRAME_ERR_EN
    errNxt = frameErr;
    if (ssFall)
      errNxt = 1'b0;
    else if (ssRise && (bitCnt != '0 || state == CMD))
      errNxt = 1'b1;
    else if (state == RDATA && shiftEdge && !ssHigh && bitCnt == '0 && !holdValid)
      errNxt = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bitCnt       <= '0;
      rxShift      <= '0;
      txShift      <= '0;
      holdReg      <= '0;
      holdValid    <= 1'b0;
      rdPend       <= 1'b0;
      oREG_ADDR    <= '0;
      oREG_WDATA   <= '0;
      oREG_WR      <= 1'b0;
      oREG_RD      <= 1'b0;
      oSPI_MISO    <= 1'b0;
      oSPI_MISO_OE <= 1'b0;
      oBUSY        <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frameErr     <= 1'b0;
`endif
    end else begin
      state        <= stateNxt;
      bitCnt       <= cntNxt;
      rxShift      <= rxNxt;
      txShift      <= txNxt;
      holdReg      <= holdNxt;
      holdValid    <= holdValidNxt;
      rdPend       <= rdPendNxt;
      oREG_ADDR    <= addrNxt;
      oREG_WDATA   <= wdataNxt;
      oREG_WR      <= wrNxt;
      oREG_RD      <= rdNxt;
      oSPI_MISO    <= txNxt[DATA_W-1];
      oSPI_MISO_OE <= ~ssHigh;
      oBUSY        <= ~ssHigh;
`ifdef SPI_FRAME_ERR_EN
      frameErr     <= errNxt;
`endif
    end
  end

`ifdef SPI_FRAME_ERR_EN
  assign oFRAME_ERR = frameErr;
`else
  assign oFRAME_ERR = 1'b0;
`endif

endmodule

// File: doc/spi_slave_regif.md
Name: spi_slave_regif

Overview:
- Parametrised successor to the existing SPI slave. All SPI inputs are oversampled in the system clock domain; nothing is clocked by SCK.
- Supports all four CPOL/CPHA modes and a configurable data word width.
- Provides multi-word write and read bursts with address auto-increment.
- Acts as the bridge between the host MCU SPI link and the FPGA register/peripheral bank, presenting a single-cycle strobe register interface.

Parameters:
DATA_W, 8, data word width in bits (8..32); the command word is always 8 bits.
ADDR_W, 7, register address width (1..7), taken from command bits [ADDR_W-1:0].
CPOL, 0, SCK idle level.
CPHA, 0, 0 = sample on the leading edge, 1 = sample on the trailing edge.

Ports:
clk  in  1  system clock; must be at least 8x the SCK frequency.
reset  in  1  synchronous, active-high reset.
iSPI_SCK  in  1  SPI clock, asynchronous.
iSPI_SS_n  in  1  slave select, active low, asynchronous.
iSPI_MOSI  in  1  master-out data, asynchronous.
oSPI_MISO  out  1  slave-out data.
oSPI_MISO_OE  out  1  MISO output enable; the top level builds the tristate.
oREG_ADDR  out  ADDR_W  current register address.
oREG_WDATA  out  DATA_W  write data; valid while oREG_WR is high.
oREG_WR  out  1  single-cycle write strobe.
oREG_RD  out  1  single-cycle read request for oREG_ADDR.
iREG_RDATA  in  DATA_W  read data.
iREG_RVALID  in  1  qualifies iREG_RDATA; one cycle.
oBUSY  out  1  frame in progress (SS_n low after synchronisation).
oFRAME_ERR  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Synchronisation: SCK, SS_n and MOSI each pass through a 2-FF synchroniser, then a 1-FF edge-detect stage. An SCK edge is acted on 3 clk after it occurs.
- Sample and shift edges: the sample edge is rising when CPOL^CPHA = 0, otherwise falling. The shift edge is the opposite edge.
- Reset: all outputs are 0 (oREG_ADDR = 0, oSPI_MISO_OE = 0). State is IDLE, the bit counter is 0 and the shift registers are 0.
- Deselect: synchronised SS_n high forces state IDLE and clears the bit counter, from any state and at any bit position. A partial word is discarded: no strobe is issued.
- oSPI_MISO_OE tracks synchronised SS_n low.
- State machine:
  - IDLE -> CMD on synchronised SS_n falling.
  - CMD: shift 8 bits MSB first on sample edges. After bit 7: latch R/W = cmd[7] (1 = write) and oREG_ADDR = cmd[ADDR_W-1:0].
    - Write: go to WDATA.
    - Read: pulse oREG_RD for 1 clk, then go to RDATA.
  - WDATA: shift DATA_W bits MSB first. On the last sample edge, on the next clk:
    - oREG_WDATA is driven with the word and oREG_WR pulses for 1 clk.
    - The following clk, oREG_ADDR increments.
    - The state remains WDATA for further words.
  - RDATA:
    - A read holding register loads on iREG_RVALID.
    - At the first shift edge of each data word (CPHA = 0: at word start), the holding register transfers to the MISO shift register.
    - If no RVALID has arrived since the request, 0 is transmitted for that word.
    - After the last bit of each word is sampled: oREG_ADDR increments, and one clk later oREG_RD pulses (prefetch for the next word).
- MISO timing: MISO is the shift register MSB and updates on shift edges.
  - CMD phase: MISO = 0.
  - CPHA = 0: the first read data bit is presented immediately after the command's last sample edge, so the read path must respond within 2 clk of oREG_RD.
  - CPHA = 1: RVALID must arrive before the next shift edge.
- Address wrap: oREG_ADDR wraps modulo 2^ADDR_W, from all-ones to 0.
- oREG_WR and oREG_RD are never high in the same cycle.
- Transfers of unbounded length are supported; only SS_n terminates a frame.

Optional Feature:
Macro SPI_FRAME_ERR_EN.
- Defined: oFRAME_ERR is a sticky flag, cleared only by reset or by the start of a new frame (SS_n falling). It is set when any of these occurs:
  - SS_n rises with the bit counter non-zero (partial word).
  - SS_n rises during CMD.
  - In RDATA, a word is transmitted without RVALID having been received.
- Not defined: oFRAME_ERR is constant 0 and no error logic is synthesised.

Test Plan:
- Mode 0, DATA_W = 8, SCK = clk/16. Frame 0x85, 0xA5, 0x3C -> oREG_WR pulses twice: (addr 0x05, data 0xA5), then (addr 0x06, data 0x3C). oREG_ADDR ends at 0x07.
- Mode 3, read. Frame 0x10 plus 2 dummy words; the bench answers RVALID with 0xC3 and 0x5A after 1 clk -> MISO shifts 0xC3 then 0x5A. oREG_RD pulses at addr 0x10, 0x11 and 0x12.
- Wrap: write command 0xFF with 2 data words, ADDR_W = 7 -> writes go to addr 0x7F, then 0x00.
- DATA_W = 16, mode 1. Write command 0x82, data 0xBEEF -> a single oREG_WR with data 0xBEEF at addr 0x02.
- Abort: SS_n rises after 4 bits of a data word -> no oREG_WR; state returns to IDLE. With SPI_FRAME_ERR_EN defined, oFRAME_ERR = 1 until the next SS_n falling edge.
- Reset asserted mid-read burst -> all outputs are 0 on the next clk. The next frame then decodes correctly from CMD.
